// File: rtl/bram_stream_reader.sv
// Streams `length` words from one block-RAM read port onto a valid/ready interface.
// A credit-controlled skid FIFO hides the RAM read latency. Define BRAM_READER_STALL_CNT_EN to add stall_cycles.
module bram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 65536,
  parameter int RD_LATENCY = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         ram_addr,
  output logic                  ram_rd_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef BRAM_READER_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int FD = RD_LATENCY + 1;
  localparam int PW = (FD > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state;
  logic [AW-1:0]           base_q, addr_hold, cur_addr;
  logic [AW:0]             len_q, issue_count, accept_count;
  logic [RD_LATENCY-1:0]   vld_sr, vld_sr_next;
  logic [DATA_WIDTH-1:0]   fifo_mem [FD];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [2:0]              fifo_count, inflight;
  logic                    pop, push, credit_ok, issue;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + {2'b00, vld_sr[i]};
    vld_sr_next    = vld_sr << 1;
    vld_sr_next[0] = issue;
  end

  assign pop       = m_valid & m_ready;
  assign push      = vld_sr[RD_LATENCY-1];
  // Credit compared without subtraction: occupancy - pop < FD  <=>  occupancy < FD + pop.
  assign credit_ok = (fifo_count + inflight) < (3'(FD) + {2'b00, pop});
  // NOTE: the read enable is decoded from registered state rather than registered itself, so a slot
  // freed by this cycle's pop is reused immediately; a registered enable would insert a bubble.
  assign issue     = (state == READ) && (issue_count != len_q) && credit_ok;
  assign cur_addr  = base_q + issue_count[AW-1:0];
  assign ram_rd_en = issue;
  assign ram_addr  = issue ? cur_addr : addr_hold;
  assign busy      = (state != IDLE);
  assign m_valid   = (fifo_count != '0);
  assign m_data    = fifo_mem[rd_ptr];

  // NOTE: FIFO storage is not reset; m_valid is gated by fifo_count, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= ram_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      done         <= 1'b0;
      base_q       <= '0;
      len_q        <= '0;
      issue_count  <= '0;
      accept_count <= '0;
      addr_hold    <= '0;
      vld_sr       <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      done       <= 1'b0;
      vld_sr     <= vld_sr_next;
      fifo_count <= fifo_count + {2'b00, push} - {2'b00, pop};
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr       <= ptr_inc(rd_ptr);
        accept_count <= accept_count + 1'b1;
      end
      if (issue) begin
        issue_count <= issue_count + 1'b1;
        addr_hold   <= cur_addr;
      end
      case (state)
        IDLE: if (start) begin
          if (length == '0) begin
            done <= 1'b1;
          end else begin
            base_q       <= base_addr;
            len_q        <= length;
            issue_count  <= '0;
            accept_count <= '0;
            state        <= READ;
          end
        end
        READ:  if (issue && (issue_count + 1'b1 == len_q)) state <= DRAIN;
        DRAIN: if (pop && (accept_count + 1'b1 == len_q)) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BRAM_READER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (state == IDLE && start) begin
      stall_cycles <= '0;
    end else if (busy && m_valid && !m_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: RAM model, scoreboard queues and a negedge monitor.
// LAT selects the RAM read latency (1 or 2); stall counter checks follow BRAM_READER_STALL_CNT_EN.
module tb_bram_stream_reader #(parameter int LAT = 2);
  localparam int DW    = 32;
  localparam int DEPTH = 65536;
  localparam int AW    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done, ram_rd_en, m_valid, m_ready;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data, m_data;
`ifdef BRAM_READER_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
    .ram_rd_data(ram_rd_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef BRAM_READER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents are a fixed function of the address; non-read cycles return garbage.
  function automatic logic [31:0] word(input int a);
    return 32'(a) ^ 32'hA500_0000;
  endfunction

  logic [DW-1:0] stg1, stg2;
  always @(posedge clk) begin
    stg1 <= ram_rd_en ? word(int'(ram_addr)) : $urandom;
    stg2 <= stg1;
  end
  assign ram_rd_data = (LAT == 1) ? stg1 : stg2;

  int pass_cnt = 0;
  int total_cnt = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Scoreboard: expected read addresses and stream words, pushed when a command is issued.
  logic [31:0] exp_data[$];
  int          exp_addr[$];
  int          first_rd, first_valid, rd_cnt, issued, accepted;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_rd_en) begin
        rd_cnt++;
        issued++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr.size() == 0) check("unexpected_read", 64'(ram_addr), 64'hFFFF_FFFF);
        else check("ram_addr", 64'(ram_addr), 64'(exp_addr.pop_front()));
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check("stalled_valid_held", 64'(m_valid), 64'd1);
        check("stalled_data_held", 64'(m_data), 64'(prev_data));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        accepted++;
        if (exp_data.size() == 0) check("unexpected_word", 64'(m_data), 64'hFFFF_FFFF_FFFF);
        else check("m_data", 64'(m_data), 64'(exp_data.pop_front()));
      end
      if (ram_rd_en || m_valid)
        check("occupancy_bound", 64'((issued - accepted) <= LAT + 1), 64'd1);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_rd_en"}, 64'(ram_rd_en), 64'd0);
    check({tag, "_addr"}, 64'(ram_addr), 64'd0);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
`ifdef BRAM_READER_STALL_CNT_EN
    check({tag, "_stall"}, 64'(stall_cycles), 64'd0);
`endif
  endtask

  task automatic push_expect(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((base + i) % DEPTH);
      exp_data.push_back(word((base + i) % DEPTH));
    end
    first_rd = -1; first_valid = -1; rd_cnt = 0; issued = 0; accepted = 0;
  endtask

  // mode 0: always ready; 1: ~50% random ready; 2: not ready for the first 10 valid cycles.
  task automatic run_cmd(input int base, input int len, input int mode);
    int ts, c, hold;
    bit junk;
    junk = (len >= 8) && (mode == 1);
    hold = 0;
    push_expect(base, len);
    m_ready   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    start     = 1'b1;
    base_addr = 16'(base);
    length    = 17'(len);
    @(posedge clk); #1;
    ts        = cyc;
    start     = 1'b0;
    base_addr = 16'($urandom);
    length    = 17'($urandom);
    if (len == 0) check("len0_busy", 64'(busy), 64'd0);
    c = 0;
    while (!done && c < len * 20 + 50) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          if (hold < 10) begin
            m_ready = 1'b0;
            if (m_valid) hold++;
          end else m_ready = 1'b1;
        end
      endcase
      start = junk && (c == 3);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 64'd0, 64'd1);
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      exp_data.delete(); exp_addr.delete();
      return;
    end
    check("done_busy_low", 64'(busy), 64'd0);
    check("rd_en_count", 64'(rd_cnt), 64'(len));
    check("words_outstanding", 64'(exp_data.size()), 64'd0);
    if (len == 0) begin
      check("len0_done_cycle", 64'(cyc), 64'(ts));
    end else begin
      check("first_rd_cycle", 64'(first_rd), 64'(ts));
      check("first_valid_cycle", 64'(first_valid), 64'(ts + 1 + LAT));
      if (mode == 0) check("done_cycle", 64'(cyc), 64'(ts + LAT + len + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d cycles expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b, l;
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    run_cmd(10, 8, 0);              // basic timing, full throughput
    run_cmd(DEPTH - 3, 6, 0);       // address wrap
    run_cmd(123, 0, 0);             // zero-length command
    run_cmd(int'($urandom_range(0, DEPTH - 1)), 64, 1);  // random backpressure

    // reset in the middle of a 32-word command
    push_expect(200, 32);
    m_ready = 1'b1; start = 1'b1; base_addr = 16'd200; length = 17'd32;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    exp_data.delete(); exp_addr.delete();
    run_cmd(0, 4, 0);

    run_cmd(500, 16, 2);            // ten stalled cycles with valid held
`ifdef BRAM_READER_STALL_CNT_EN
    check("stall_count_after_done", 64'(stall_cycles), 64'd10);
`endif
    run_cmd(7, 4, 0);
`ifdef BRAM_READER_STALL_CNT_EN
    check("stall_count_cleared", 64'(stall_cycles), 64'd0);
`endif

    for (int k = 0; k < 12; k++) begin
      b = ($urandom_range(0, 3) == 0) ? DEPTH - int'($urandom_range(1, 20))
                                      : int'($urandom_range(0, DEPTH - 1));
      l = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      run_cmd(b, l, int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
